// File: rtl/bf_sequencer.sv
// Brainfuck instruction sequencer: fetches program bytes, walks data cells over a
// single request/ack memory port, and streams '.' output and ',' input via valid/ready.
module bf_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int PC_W    = 12,
    parameter int PTR_W   = 12,
    parameter int DEPTH_W = 8,
    parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(16'h8000)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              halted,
    output logic              error,
    output logic [3:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid (mem_req/out_valid/in_valid)
    // and ready (mem_ack/out_ready/in_ready) are both high and en is high; valid-side
    // outputs are pure functions of state, so they stay stable until that edge.

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_NEXT_PC, S_RD, S_MOD, S_WR, S_OUT, S_IN, S_HALT
    } state_t;

    localparam logic [DATA_W-1:0] CH_INC   = DATA_W'(8'h2B);
    localparam logic [DATA_W-1:0] CH_DEC   = DATA_W'(8'h2D);
    localparam logic [DATA_W-1:0] CH_RIGHT = DATA_W'(8'h3E);
    localparam logic [DATA_W-1:0] CH_LEFT  = DATA_W'(8'h3C);
    localparam logic [DATA_W-1:0] CH_OUT   = DATA_W'(8'h2E);
    localparam logic [DATA_W-1:0] CH_IN    = DATA_W'(8'h2C);
    localparam logic [DATA_W-1:0] CH_LOOP  = DATA_W'(8'h5B);
    localparam logic [DATA_W-1:0] CH_END   = DATA_W'(8'h5D);
    localparam logic [DATA_W-1:0] CH_NUL   = '0;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]    cell_q, cell_d;
    logic [DATA_W-1:0]    instr_q, instr_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 scan_q, scan_d;
    logic                 dir_q, dir_d;
    logic                 error_q, error_d;
    // Low for the first cycle after reset so no request is raised while reset is applied.
    logic                 live_q;

    logic [ADDR_W-1:0]    pc_addr;
    logic [ADDR_W-1:0]    data_addr;

    assign pc_addr   = {{(ADDR_W-PC_W){1'b0}}, pc_q};
    assign data_addr = DATA_BASE + {{(ADDR_W-PTR_W){1'b0}}, ptr_q};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ptr_q   <= '0;
            cell_q  <= '0;
            instr_q <= '0;
            depth_q <= '0;
            scan_q  <= 1'b0;
            dir_q   <= 1'b0;
            error_q <= 1'b0;
            live_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cell_q  <= cell_d;
            instr_q <= instr_d;
            depth_q <= depth_d;
            scan_q  <= scan_d;
            dir_q   <= dir_d;
            error_q <= error_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        cell_d    = cell_q;
        instr_d   = instr_q;
        depth_d   = depth_q;
        scan_d    = scan_q;
        dir_d     = dir_q;
        error_d   = error_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = cell_q;
        out_valid = 1'b0;
        in_ready  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (live_q) begin
                    mem_req  = 1'b1;
                    mem_addr = pc_addr;
                    if (mem_ack) begin
                        instr_d = mem_rdata;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (scan_q) begin
                    if (instr_q == CH_NUL) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_NEXT_PC;
                        // Opening bracket in the scan direction nests deeper; closing one unwinds.
                        if (instr_q == (dir_q ? CH_END : CH_LOOP)) begin
                            if (depth_q == '1) begin
                                error_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                depth_d = depth_q + DEPTH_W'(1);
                            end
                        end else if (instr_q == (dir_q ? CH_LOOP : CH_END)) begin
                            depth_d = depth_q - DEPTH_W'(1);
                            if (depth_q == DEPTH_W'(1)) scan_d = 1'b0;
                        end
                    end
                end else begin
                    case (instr_q)
                        CH_INC, CH_DEC, CH_LOOP, CH_END, CH_OUT: state_d = S_RD;
                        CH_RIGHT: begin
                            ptr_d   = ptr_q + PTR_W'(1);
                            state_d = S_NEXT_PC;
                        end
                        CH_LEFT: begin
                            ptr_d   = ptr_q - PTR_W'(1);
                            state_d = S_NEXT_PC;
                        end
                        CH_IN:   state_d = S_IN;
                        CH_NUL:  state_d = S_HALT;
                        default: state_d = S_NEXT_PC;
                    endcase
                end
            end
            S_NEXT_PC: begin
                pc_d    = (scan_q && dir_q) ? pc_q - PC_W'(1) : pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            S_RD: begin
                mem_req  = 1'b1;
                mem_addr = data_addr;
                if (mem_ack) begin
                    cell_d  = mem_rdata;
                    state_d = (instr_q == CH_OUT) ? S_OUT : S_MOD;
                end
            end
            S_MOD: begin
                state_d = S_NEXT_PC;
                if (instr_q == CH_INC) begin
                    cell_d  = cell_q + DATA_W'(1);
                    state_d = S_WR;
                end else if (instr_q == CH_DEC) begin
                    cell_d  = cell_q - DATA_W'(1);
                    state_d = S_WR;
                end else if ((instr_q == CH_LOOP && cell_q == '0) ||
                             (instr_q == CH_END && cell_q != '0)) begin
                    scan_d  = 1'b1;
                    dir_d   = (instr_q == CH_END);
                    depth_d = DEPTH_W'(1);
                end
            end
            S_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = data_addr;
                if (mem_ack) state_d = S_NEXT_PC;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_NEXT_PC;
            end
            S_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cell_d  = in_data;
                    state_d = S_WR;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    assign out_data    = cell_q;
    assign halted      = (state_q == S_HALT);
    assign error       = error_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bf_sequencer.sv
// Bench for bf_sequencer: behavioural memory, table of programs run with steady and
// randomised handshakes, plus hand sequences for input/output stalls and mid-run reset.
module tb_bf_sequencer;

    logic        clk = 1'b0;
    logic        nreset, en;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        out_valid, out_ready, in_valid, in_ready;
    logic [7:0]  out_data, in_data;
    logic        halted, error;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    bf_sequencer #(.DEPTH_W(2)) dut (
        .clk(clk), .nreset(nreset), .en(en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .halted(halted), .error(error), .dbg_state_o(dbg_state)
    );

    typedef struct {
        logic [127:0] prog;
        int           len;
        logic [15:0]  pre_addr;
        logic [7:0]   pre_val;
        logic         has_out;
        logic [7:0]   exp_out;
        logic         exp_err;
        logic [15:0]  exp_fetch;
        logic [15:0]  c0_addr;
        logic [7:0]   c0_val;
        logic [15:0]  c1_addr;
        logic [7:0]   c1_val;
    } vec_t;

    vec_t tbl [8];

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    logic        rnd, or_force;
    logic        hold_pend, stall_pend;
    logic [37:0] cur, snap;
    logic [7:0]  stall_data;
    logic [15:0] last_fetch;
    int          in_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples the cycle's final inputs/outputs, models the memory and streams, then advances.
    task automatic tick();
        int n;
        if (rnd) begin
            mem_ack   = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
        end else begin
            mem_ack   = 1'b1;
            en        = 1'b1;
            out_ready = or_force;
        end
        cur = {mem_req, mem_we, mem_addr, mem_wdata, out_valid, out_data, in_ready, halted, error};
        if (hold_pend) check("hold_en_low", 64'(cur), 64'(snap));
        if (stall_pend) check("out_stable", {out_valid, out_data}, {1'b1, stall_data});
        n = int'(mem_req) + int'(out_valid) + int'(in_ready);
        check("one_active", 64'(n <= 1), 1);
        check("err_implies_halt", 64'(error && !halted), 0);
        if (nreset && en) begin
            if (mem_req && mem_ack) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                else if (mem_addr < 16'h8000) last_fetch = mem_addr;
            end
            if (out_valid && out_ready) begin
                check("out_pending", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) in_cnt++;
        end
        hold_pend  = nreset && !en;
        snap       = cur;
        stall_pend = nreset && out_valid && !out_ready;
        stall_data = out_data;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] p, input int len);
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < len; i++) mem[i] = p[8*(len-1-i) +: 8];
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tick();
        tick();
        check("rst_outs", {mem_req, out_valid, in_ready, halted, error}, 0);
        check("rst_state", 64'(dbg_state), 0);
        nreset = 1'b1;
        tick();
        if (!rnd) check("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0000});
    endtask

    task automatic wait_halt(input int budget);
        int i = 0;
        while (!halted && i < budget) begin
            tick();
            i++;
        end
        check("halt_reached", 64'(halted), 1);
    endtask

    task automatic run_row(input vec_t v, input string tag);
        load(v.prog, v.len);
        mem[v.pre_addr] = v.pre_val;
        exp_q.delete();
        if (v.has_out) exp_q.push_back(v.exp_out);
        last_fetch = 16'hFFFF;
        do_reset();
        wait_halt(4000);
        check({tag, "_error"}, 64'(error), 64'(v.exp_err));
        check({tag, "_out_drained"}, 64'(exp_q.size()), 0);
        check({tag, "_last_fetch"}, 64'(last_fetch), 64'(v.exp_fetch));
        check({tag, "_cell_a"}, 64'(mem[v.c0_addr]), 64'(v.c0_val));
        check({tag, "_cell_b"}, 64'(mem[v.c1_addr]), 64'(v.c1_val));
        tick();
        tick();
        check({tag, "_halt_quiet"}, {mem_req, out_valid, in_ready, halted}, 4'b0001);
    endtask

    initial begin
        tbl[0] = '{"+++.",         4,  16'h8000, 8'h00, 1'b1, 8'h03, 1'b0, 16'd4,   16'h8000, 8'h03, 16'h8001, 8'h00};
        tbl[1] = '{"-.",           2,  16'h8000, 8'h00, 1'b1, 8'hFF, 1'b0, 16'd2,   16'h8000, 8'hFF, 16'h8001, 8'h00};
        tbl[2] = '{"[+[]+]+.",     8,  16'h8000, 8'h00, 1'b1, 8'h01, 1'b0, 16'd8,   16'h8000, 8'h01, 16'h8001, 8'h00};
        tbl[3] = '{"+++[>++<-]>.", 12, 16'h8000, 8'h00, 1'b1, 8'h06, 1'b0, 16'd12,  16'h8000, 8'h00, 16'h8001, 8'h06};
        tbl[4] = '{"><<.",         4,  16'h8FFF, 8'h5A, 1'b1, 8'h5A, 1'b0, 16'd4,   16'h8FFF, 8'h5A, 16'h8000, 8'h00};
        tbl[5] = '{"[",            1,  16'h8000, 8'h00, 1'b0, 8'h00, 1'b0, 16'd1,   16'h8000, 8'h00, 16'h8001, 8'h00};
        tbl[6] = '{"[[[[",         4,  16'h8000, 8'h00, 1'b0, 8'h00, 1'b1, 16'd3,   16'h8000, 8'h00, 16'h8001, 8'h00};
        tbl[7] = '{"+>+<]",        5,  16'h8000, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0FFF, 16'h8000, 8'h01, 16'h8001, 8'h01};

        nreset = 1'b0; en = 1'b1; mem_ack = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
        rnd = 1'b0; or_force = 1'b1;
        hold_pend = 1'b0; stall_pend = 1'b0; snap = '0; stall_data = 8'h00;
        last_fetch = 16'h0000; in_cnt = 0;
        @(negedge clk);
        #1;

        for (int pass = 0; pass < 2; pass++) begin
            rnd = (pass == 1);
            for (int r = 0; r < 8; r++) run_row(tbl[r], $sformatf("row%0d_p%0d", r, pass));
        end

        // ',' waits five idle cycles for input, then '.' is held off by out_ready for three.
        rnd = 1'b0; or_force = 1'b0;
        load(",.", 2);
        exp_q.delete();
        exp_q.push_back(8'h41);
        in_cnt = 0;
        do_reset();
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check("in_ready_up", 64'(in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("in_idle_wait", {in_ready, mem_req, dbg_state}, {1'b1, 1'b0, 4'd7});
        end
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        check("in_taken", 64'(in_cnt), 1);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        check("out_valid_up", 64'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("out_held", {out_valid, out_data}, {1'b1, 8'h41});
        end
        or_force = 1'b1;
        wait_halt(200);
        check("io_out_drained", 64'(exp_q.size()), 0);
        check("io_cell0", 64'(mem[16'h8000]), 64'h41);
        check("io_error", 64'(error), 0);

        // Reset part-way through "+++." restarts cleanly from pc 0.
        load("+++.", 4);
        exp_q.delete();
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        nreset = 1'b0;
        tick();
        check("midrst_outs", {mem_req, out_valid, in_ready, halted, error}, 0);
        check("midrst_state", 64'(dbg_state), 0);
        mem[16'h8000] = 8'h00;
        exp_q.push_back(8'h03);
        nreset = 1'b1;
        tick();
        check("midrst_fetch0", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0000});
        wait_halt(400);
        check("midrst_out_drained", 64'(exp_q.size()), 0);
        check("midrst_cell0", 64'(mem[16'h8000]), 64'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
